// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage load/store sequencer.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    localparam logic [31:0] LOAD_ERR_VALUE  = 32'h0000_0000;
    localparam int          DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Request/acknowledge bus between the MEM-stage sequencer and data memory.
interface mem_stage_ctrl_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_stage_ctrl_wait_timer.sv
// Counts unacknowledged WAIT cycles; o_expired flags the cycle that reaches LIMIT.
module wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clock or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_enable)
            r_cnt <= r_cnt + 1'b1;
    end

    // The enabled cycle that would bring the count to LIMIT is the expiry cycle.
    assign o_expired = i_enable && (r_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage load/store sequencer: one request/ack transaction per EX/MEM access.
// Optional macro MEM_TIMEOUT_EN bounds WAIT to TIMEOUT_CYCLES and reports mem_err.
module mem_stage_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     ex_mread,
    input  logic                     ex_mwrite,
    input  logic [31:0]              ex_addr,
    input  logic [31:0]              ex_wdata,
    mem_stage_ctrl_if.master         mem,
    output logic                     stall,
    output logic [31:0]              load_data,
    output logic                     load_valid,
    output logic                     mem_err
);

    mem_state_t  r_state, w_next;
    logic        w_access;
    logic        w_timeout;
    logic        r_req, r_we, r_load_valid;
    logic [31:0] r_addr, r_wdata, r_load_data;

    assign w_access = ex_mread | ex_mwrite;

    always_ff @(posedge clock or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stall = w_access;
                if (w_access)
                    w_next = ST_WAIT;
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (mem.mem_ack || w_timeout)
                    w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // A store wins over a simultaneous load, so mem_we simply follows ex_mwrite.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_req        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        r_req   <= 1'b1;
                        r_we    <= ex_mwrite;
                        r_addr  <= ex_addr;
                        r_wdata <= ex_wdata;
                    end
                end
                ST_WAIT: begin
                    if (mem.mem_ack) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_load_data  <= mem.mem_rdata;
                            r_load_valid <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_load_data  <= LOAD_ERR_VALUE;
                            r_load_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic r_err;

    // Ack has priority: the timer only advances (and can only expire) without ack.
    wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
        .clock     (clock),
        .rst       (rst),
        .i_clear   (r_state != ST_WAIT),
        .i_enable  ((r_state == ST_WAIT) && !mem.mem_ack),
        .o_expired (w_timeout)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else
            r_err <= w_timeout;
    end

    assign mem_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign load_data     = r_load_data;
    assign load_valid    = r_load_valid;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed table, reset abort, and randomized ops vs a transaction model.
module tb_mem_stage_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO_LIM = 4;

    typedef struct {
        bit          rd, wr, tied;
        logic [31:0] addr, wdata, rdata;
        int          lat;
        bit          exp_we;
        int          exp_req, exp_stall, exp_lv, exp_err;
        logic [31:0] exp_ld;
    } vec_t;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        ex_mread = 1'b0, ex_mwrite = 1'b0;
    logic [31:0] ex_addr = '0, ex_wdata = '0;
    logic        stall, load_valid, mem_err;
    logic [31:0] load_data;
    int          n_vec = 0, n_miss = 0;
    logic [31:0] ld_model = '0;
    vec_t        tbl[$];

    mem_stage_ctrl_if u_if();

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TO_LIM)) dut (
        .clock      (clock),
        .rst        (rst),
        .ex_mread   (ex_mread),
        .ex_mwrite  (ex_mwrite),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .mem        (u_if),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .mem_err    (mem_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rd, bit wr, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, int lat, bit tied, bit exp_we, int exp_req,
                                int exp_stall, int exp_lv, int exp_err, logic [31:0] exp_ld);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.lat = lat; v.tied = tied; v.exp_we = exp_we; v.exp_req = exp_req;
        v.exp_stall = exp_stall; v.exp_lv = exp_lv; v.exp_err = exp_err; v.exp_ld = exp_ld;
        return v;
    endfunction

    // Called just after a rising edge; returns just after the edge that ends DONE.
    task automatic run_op(input vec_t v, input string tag);
        int reqc = 0, stc = 0, lvc = 0, errc = 0, bad = 0, cyc = 0;
        bit done = 0;
        logic [31:0] ld = 'x;
        ex_mread = v.rd; ex_mwrite = v.wr; ex_addr = v.addr; ex_wdata = v.wdata;
        u_if.mem_ack = v.tied;
        if (v.tied) u_if.mem_rdata = v.rdata;
        while (!done && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (u_if.mem_req) begin
                reqc++;
                if (u_if.mem_addr !== v.addr || u_if.mem_we !== v.exp_we ||
                    u_if.mem_wdata !== v.wdata) bad++;
            end
            if (stall) stc++;
            if (load_valid) lvc++;
            if (mem_err) errc++;
            if (v.tied) begin
                u_if.mem_ack = 1'b1; u_if.mem_rdata = v.rdata;
            end else if (u_if.mem_req && reqc == v.lat + 1) begin
                u_if.mem_ack = 1'b1; u_if.mem_rdata = v.rdata;
            end else begin
                u_if.mem_ack = 1'b0; u_if.mem_rdata = $urandom;
            end
            if (!stall) begin
                done = 1;
                ld = load_data;
            end
        end
        chk({tag, " completed"}, 32'(done), 32'd1);
        chk({tag, " req_cycles"}, 32'(reqc), 32'(v.exp_req));
        chk({tag, " stall_cycles"}, 32'(stc), 32'(v.exp_stall));
        chk({tag, " load_valid_pulses"}, 32'(lvc), 32'(v.exp_lv));
        chk({tag, " mem_err_pulses"}, 32'(errc), 32'(v.exp_err));
        chk({tag, " bus_unstable_cycles"}, 32'(bad), 32'd0);
        chk({tag, " load_data"}, ld, v.exp_ld);
        @(posedge clock); #1;
        ex_mread = 1'b0; ex_mwrite = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        ex_mread = 1'b0; ex_mwrite = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk("idle stall", {31'd0, stall}, 32'd0);
            chk("idle mem_req", {31'd0, u_if.mem_req}, 32'd0);
            @(posedge clock); #1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " mem_req"}, {31'd0, u_if.mem_req}, 32'd0);
        chk({tag, " mem_we"}, {31'd0, u_if.mem_we}, 32'd0);
        chk({tag, " stall"}, {31'd0, stall}, 32'd0);
        chk({tag, " load_valid"}, {31'd0, load_valid}, 32'd0);
        chk({tag, " mem_err"}, {31'd0, mem_err}, 32'd0);
        chk({tag, " mem_addr"}, u_if.mem_addr, 32'd0);
        chk({tag, " mem_wdata"}, u_if.mem_wdata, 32'd0);
        chk({tag, " load_data"}, load_data, 32'd0);
    endtask

    initial begin
        u_if.mem_ack = 1'b0;
        u_if.mem_rdata = '0;
        #1 rst = 1'b1;
        #12 chk_zero("reset");
        @(negedge clock) rst = 1'b0;
        @(posedge clock); #1;

        // Directed table; a 5-cycle store latency exceeds the timeout limit when enabled.
        tbl.push_back(mk(1, 0, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 1, 2, 1, 0, 32'hCAFE_F00D));
        tbl.push_back(mk(0, 1, 32'h0000_0020, 32'h1234_5678, 32'h0, 5, 0, 1,
                         TO_EN ? 4 : 6, TO_EN ? 5 : 7, 0, TO_EN ? 1 : 0, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 1, 32'h0000_0030, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 2, 0, 1, 3, 4, 0, 0, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 0, 32'h0000_0044, 32'h0, 32'h1111_2222, 0, 1, 0, 1, 2, 1, 0, 32'h1111_2222));
        tbl.push_back(mk(0, 1, 32'h0000_0048, 32'h3333_4444, 32'h5555_6666, 0, 1, 1, 1, 2, 0, 0, 32'h1111_2222));
        tbl.push_back(mk(1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h8000_0001, 3, 0, 0, 4, 5, 1, 0, 32'h8000_0001));
        if (TO_EN) begin
            tbl.push_back(mk(1, 0, 32'h0000_0050, 32'h0, 32'h7777_7777, 100, 0, 0, 4, 5, 1, 1, 32'h0000_0000));
            tbl.push_back(mk(1, 0, 32'h0000_0054, 32'h0, 32'h0BAD_F00D, 3, 0, 0, 4, 5, 1, 0, 32'h0BAD_F00D));
        end
        foreach (tbl[i]) run_op(tbl[i], $sformatf("tbl%0d", i));
        u_if.mem_ack = 1'b0;
        idle_cycles(2);

        // Reset while WAITing: outputs drop before the next clock edge.
        ex_mread = 1'b1; ex_addr = 32'h0000_0100; ex_wdata = 32'h0000_BEEF;
        repeat (3) @(negedge clock);
        chk("pre-reset mem_req", {31'd0, u_if.mem_req}, 32'd1);
        chk("pre-reset stall", {31'd0, stall}, 32'd1);
        #2 rst = 1'b1; ex_mread = 1'b0;
        #1 chk_zero("async reset");
        @(negedge clock) rst = 1'b0;
        @(posedge clock); #1;
        idle_cycles(2);
        ld_model = '0;

        // Random ops against a transaction-level model of the timing rules.
        for (int n = 0; n < 40; n++) begin
            vec_t v;
            int sel, lat;
            bit timed;
            sel = $urandom_range(0, 2);
            lat = $urandom_range(0, 6);
            v.rd = (sel != 1); v.wr = (sel != 0); v.tied = 0;
            v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom; v.lat = lat;
            timed = TO_EN && (lat >= TO_LIM);
            v.exp_we = v.wr;
            v.exp_req = timed ? TO_LIM : lat + 1;
            v.exp_stall = v.exp_req + 1;
            v.exp_lv = v.wr ? 0 : 1;
            v.exp_err = timed ? 1 : 0;
            if (!v.wr) ld_model = timed ? 32'h0 : v.rdata;
            v.exp_ld = ld_model;
            run_op(v, $sformatf("rnd%0d", n));
            idle_cycles($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
